// File: rtl/ycr_pipe_wb_arb_pkg.sv
// Shared writeback types: FIFO entry layout and default sizing.
// Widths fall back to RV32 defaults when the core-wide macros are absent.
`ifndef YCR_MPRF_AWIDTH
`define YCR_MPRF_AWIDTH 5
`endif
`ifndef YCR_XLEN
`define YCR_XLEN 32
`endif

package ycr_pipe_wb_arb_pkg;

    localparam int YCR_WB_FIFO_DEPTH = 2;
    localparam int YCR_WB_AWIDTH     = `YCR_MPRF_AWIDTH;
    localparam int YCR_WB_XLEN       = `YCR_XLEN;

    typedef struct packed {
        logic [YCR_WB_AWIDTH-1:0] rd_addr;
        logic [YCR_WB_XLEN-1:0]   rd_data;
    } type_ycr_wb_entry_s;

    localparam int YCR_WB_ENTRY_W = $bits(type_ycr_wb_entry_s);

    function automatic logic wb_is_x0(input logic [YCR_WB_AWIDTH-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/ycr_wb_fifo.sv
// Small synchronous FIFO buffering LSU load returns until the write port is free.
// DEPTH must be a power of two so the pointers wrap without compare logic.
module ycr_wb_fifo
    import ycr_pipe_wb_arb_pkg::*;
#(
    parameter int DEPTH = YCR_WB_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [YCR_WB_ENTRY_W-1:0] din,
    input  logic                      pop,
    output logic [YCR_WB_ENTRY_W-1:0] dout,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [YCR_WB_ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]             rptr;
    logic [PW-1:0]             wptr;
    logic [PW:0]               count;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/ycr_pipe_wb_arb.sv
// Writeback arbiter for the single MPRF write port plus pending-load scoreboard.
// Optional YCR_WB_FWD_EN adds a bypass of the value being written this cycle.
module ycr_pipe_wb_arb
    import ycr_pipe_wb_arb_pkg::*;
#(
    parameter int WB_FIFO_DEPTH = YCR_WB_FIFO_DEPTH,
    parameter int WB_AWIDTH     = YCR_WB_AWIDTH,
    parameter int WB_XLEN       = YCR_WB_XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu2wb_vd_i,
    input  logic [WB_AWIDTH-1:0] alu2wb_rd_addr_i,
    input  logic [WB_XLEN-1:0]   alu2wb_rd_data_i,
    input  logic                 lsu2wb_vd_i,
    output logic                 wb2lsu_rdy_o,
    input  logic [WB_AWIDTH-1:0] lsu2wb_rd_addr_i,
    input  logic [WB_XLEN-1:0]   lsu2wb_rd_data_i,
    input  logic                 exu2wb_ld_issue_i,
    input  logic [WB_AWIDTH-1:0] exu2wb_ld_rd_i,
    input  logic [WB_AWIDTH-1:0] exu2wb_rs1_addr_i,
    input  logic [WB_AWIDTH-1:0] exu2wb_rs2_addr_i,
    input  logic [WB_AWIDTH-1:0] exu2wb_rd_addr_i,
    output logic                 wb2exu_hazard_o,
    output logic                 exu2mprf_w_req_o,
    output logic [WB_AWIDTH-1:0] exu2mprf_rd_addr_o,
    output logic [WB_XLEN-1:0]   exu2mprf_rd_data_o,
    output logic                 wb2exu_fwd_rs1_vd_o,
    output logic                 wb2exu_fwd_rs2_vd_o,
    output logic [WB_XLEN-1:0]   wb2exu_fwd_data_o
);

    localparam int NREGS = 2**WB_AWIDTH;

    type_ycr_wb_entry_s   push_entry;
    type_ycr_wb_entry_s   head_entry;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 lsu_push;
    logic                 fifo_pop;

    logic                 sel_vd;
    logic [WB_AWIDTH-1:0] sel_addr;
    logic [WB_XLEN-1:0]   sel_data;
    logic                 wr_from_lsu;

    logic [NREGS-1:0]     pending;
    logic [NREGS-1:0]     pending_nxt;

    assign push_entry.rd_addr = lsu2wb_rd_addr_i;
    assign push_entry.rd_data = lsu2wb_rd_data_i;

    assign wb2lsu_rdy_o = !fifo_full;
    assign lsu_push     = lsu2wb_vd_i & wb2lsu_rdy_o;
    // ALU has no backpressure, so buffered loads only drain in ALU-idle cycles
    assign fifo_pop     = !alu2wb_vd_i & !fifo_empty;

    ycr_wb_fifo #(
        .DEPTH (WB_FIFO_DEPTH)
    ) i_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lsu_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        sel_vd   = alu2wb_vd_i | !fifo_empty;
        sel_addr = alu2wb_vd_i ? alu2wb_rd_addr_i : head_entry.rd_addr;
        sel_data = alu2wb_vd_i ? alu2wb_rd_data_i : head_entry.rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exu2mprf_w_req_o   <= 1'b0;
            exu2mprf_rd_addr_o <= '0;
            exu2mprf_rd_data_o <= '0;
            wr_from_lsu        <= 1'b0;
        end else begin
            exu2mprf_w_req_o <= sel_vd & !wb_is_x0(sel_addr);
            wr_from_lsu      <= fifo_pop;
            if (sel_vd) begin
                exu2mprf_rd_addr_o <= sel_addr;
                exu2mprf_rd_data_o <= sel_data;
            end
        end
    end

    // Clear on load commit first, then set, so a newer load to the same rd stays pending
    always_comb begin
        pending_nxt = pending;
        if (exu2mprf_w_req_o & wr_from_lsu)
            pending_nxt[exu2mprf_rd_addr_o] = 1'b0;
        if (exu2wb_ld_issue_i & !wb_is_x0(exu2wb_ld_rd_i))
            pending_nxt[exu2wb_ld_rd_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    assign wb2exu_hazard_o = (!wb_is_x0(exu2wb_rs1_addr_i) & pending[exu2wb_rs1_addr_i])
                           | (!wb_is_x0(exu2wb_rs2_addr_i) & pending[exu2wb_rs2_addr_i])
                           | (!wb_is_x0(exu2wb_rd_addr_i)  & pending[exu2wb_rd_addr_i]);

`ifdef YCR_WB_FWD_EN
    assign wb2exu_fwd_rs1_vd_o = exu2mprf_w_req_o & !wb_is_x0(exu2wb_rs1_addr_i)
                               & (exu2wb_rs1_addr_i == exu2mprf_rd_addr_o);
    assign wb2exu_fwd_rs2_vd_o = exu2mprf_w_req_o & !wb_is_x0(exu2wb_rs2_addr_i)
                               & (exu2wb_rs2_addr_i == exu2mprf_rd_addr_o);
    assign wb2exu_fwd_data_o   = exu2mprf_rd_data_o;
`else
    assign wb2exu_fwd_rs1_vd_o = 1'b0;
    assign wb2exu_fwd_rs2_vd_o = 1'b0;
    assign wb2exu_fwd_data_o   = '0;
`endif

`ifndef SYNTHESIS
    // EXU must stall on an rd hazard, so an ALU write never targets a pending register
    alu_wr_to_pending : assert property (@(posedge clk) disable iff (!rst_n)
        !(alu2wb_vd_i && !wb_is_x0(alu2wb_rd_addr_i) && pending[alu2wb_rd_addr_i]));
`endif

endmodule

// File: tb/tb_ycr_pipe_wb_arb.sv
// Self-checking bench for ycr_pipe_wb_arb: directed scenarios plus a randomized run
// against a queue-based reference model of the writeback rules.
module tb_ycr_pipe_wb_arb;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        alu_vd;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_vd;
    logic        lsu_rdy;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic [4:0]  rs1, rs2, rd;
    logic        hazard;
    logic        w_req;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        fwd1, fwd2;
    logic [31:0] fwd_data;

    int n_cmp = 0;
    int n_err = 0;

    ycr_pipe_wb_arb #(.WB_FIFO_DEPTH(DEPTH), .WB_AWIDTH(5), .WB_XLEN(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .alu2wb_vd_i         (alu_vd),
        .alu2wb_rd_addr_i    (alu_addr),
        .alu2wb_rd_data_i    (alu_data),
        .lsu2wb_vd_i         (lsu_vd),
        .wb2lsu_rdy_o        (lsu_rdy),
        .lsu2wb_rd_addr_i    (lsu_addr),
        .lsu2wb_rd_data_i    (lsu_data),
        .exu2wb_ld_issue_i   (ld_issue),
        .exu2wb_ld_rd_i      (ld_rd),
        .exu2wb_rs1_addr_i   (rs1),
        .exu2wb_rs2_addr_i   (rs2),
        .exu2wb_rd_addr_i    (rd),
        .wb2exu_hazard_o     (hazard),
        .exu2mprf_w_req_o    (w_req),
        .exu2mprf_rd_addr_o  (w_addr),
        .exu2mprf_rd_data_o  (w_data),
        .wb2exu_fwd_rs1_vd_o (fwd1),
        .wb2exu_fwd_rs2_vd_o (fwd2),
        .wb2exu_fwd_data_o   (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [31:0] pend_m;
    logic [4:0]  mq_a[$];
    logic [31:0] mq_d[$];
    logic        m_req, m_lsu;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_vd = 0; alu_addr = 0; alu_data = 0;
        lsu_vd = 0; lsu_addr = 0; lsu_data = 0;
        ld_issue = 0; ld_rd = 0; rs1 = 0; rs2 = 0; rd = 0;
    endtask

    task automatic model_reset();
        pend_m = 0; mq_a.delete(); mq_d.delete();
        m_req = 0; m_lsu = 0; m_addr = 0; m_data = 0;
    endtask

    // advance the model by one clock using the inputs currently driven
    task automatic model_step();
        bit          push = lsu_vd && (mq_a.size() < DEPTH);
        bit          sel = 0, nlsu = 0;
        logic [4:0]  naddr = 0;
        logic [31:0] ndata = 0;
        if (alu_vd) begin
            sel = 1; naddr = alu_addr; ndata = alu_data;
        end else if (mq_a.size() > 0) begin
            sel = 1; nlsu = 1; naddr = mq_a.pop_front(); ndata = mq_d.pop_front();
        end
        if (m_req && m_lsu) pend_m[m_addr] = 1'b0;
        if (ld_issue && ld_rd != 0) pend_m[ld_rd] = 1'b1;
        if (push) begin mq_a.push_back(lsu_addr); mq_d.push_back(lsu_data); end
        m_req = sel && naddr != 0;
        m_lsu = sel && nlsu;
        if (sel) begin m_addr = naddr; m_data = ndata; end
    endtask

    task automatic test_reset();
        idle(); rs1 = 3; rs2 = 4; rd = 5;
        rst_n = 0;
        #12;
        n_cmp++; if (lsu_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", lsu_rdy); end
        n_cmp++; if (w_req !== 1'b0) begin n_err++; $display("FAIL reset_wreq: got %b want 0", w_req); end
        n_cmp++; if (w_addr !== 5'd0 || w_data !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %0h/%0h want 0/0", w_addr, w_data); end
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard: got %b want 0", hazard); end
        n_cmp++; if ({fwd1, fwd2} !== 2'b00 || fwd_data !== 32'd0) begin n_err++; $display("FAIL reset_fwd: got %b%b/%0h want 00/0", fwd1, fwd2, fwd_data); end
        @(negedge clk) rst_n = 1;
        tick();
    endtask

    task automatic test_alu_basic();
        idle();
        alu_vd = 1; alu_addr = 5; alu_data = 32'h11;
        tick();
        idle(); rs1 = 5; rs2 = 5; rd = 5;
        @(negedge clk);
        n_cmp++; if ({w_req, w_addr, w_data} !== {1'b1, 5'd5, 32'h11}) begin n_err++; $display("FAIL alu_basic_write: got %b/%0d/%0h want 1/5/11", w_req, w_addr, w_data); end
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL alu_basic_hazard: got %b want 0", hazard); end
        tick();
        n_cmp++; if (w_req !== 1'b0) begin n_err++; $display("FAIL alu_basic_single: got %b want 0", w_req); end
    endtask

    task automatic test_load_hazard();
        idle();
        ld_issue = 1; ld_rd = 7; rs1 = 7;
        tick();
        ld_issue = 0; lsu_vd = 1; lsu_addr = 7; lsu_data = 32'hDEAD;
        @(negedge clk);
        n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL ld_hazard_set: got %b want 1", hazard); end
        tick();
        lsu_vd = 0;
        @(negedge clk);
        n_cmp++; if (hazard !== 1'b1 || w_req !== 1'b0) begin n_err++; $display("FAIL ld_hazard_wait: got haz %b req %b want 1 0", hazard, w_req); end
        tick();
        @(negedge clk);
        n_cmp++; if ({w_req, w_addr, w_data} !== {1'b1, 5'd7, 32'hDEAD}) begin n_err++; $display("FAIL ld_commit: got %b/%0d/%0h want 1/7/dead", w_req, w_addr, w_data); end
        tick();
        @(negedge clk);
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL ld_hazard_clear: got %b want 0", hazard); end
        tick();
    endtask

    task automatic test_burst();
        logic [4:0]  oa[$];
        logic [31:0] od[$];
        logic [4:0]  ea[7];
        logic [31:0] ed[7];
        int li = 0;
        for (int i = 0; i < 4; i++) begin ea[i] = 5'(10 + i); ed[i] = 32'h100 + i; end
        for (int i = 0; i < 3; i++) begin ea[4+i] = 5'(20 + i); ed[4+i] = 32'hA0 + i; end
        idle();
        for (int c = 0; c < 14; c++) begin
            alu_vd = (c < 4); alu_addr = 5'(10 + c); alu_data = 32'h100 + c;
            lsu_vd = (li < 3); lsu_addr = 5'(20 + li); lsu_data = 32'hA0 + li;
            @(negedge clk);
            if (c == 2 || c == 3) begin
                n_cmp++; if (lsu_rdy !== 1'b0) begin n_err++; $display("FAIL burst_rdy_low c%0d: got %b want 0", c, lsu_rdy); end
            end
            if (w_req) begin oa.push_back(w_addr); od.push_back(w_data); end
            if (lsu_vd && lsu_rdy) li++;
            tick();
        end
        idle();
        n_cmp++; if (oa.size() != 7) begin n_err++; $display("FAIL burst_count: got %0d want 7", oa.size()); end
        for (int i = 0; i < 7 && i < oa.size(); i++) begin
            n_cmp++; if (oa[i] !== ea[i] || od[i] !== ed[i]) begin n_err++; $display("FAIL burst_order[%0d]: got %0d/%0h want %0d/%0h", i, oa[i], od[i], ea[i], ed[i]); end
        end
    endtask

    task automatic test_x0_load();
        idle();
        lsu_vd = 1; lsu_addr = 0; lsu_data = 32'h5;
        tick();
        lsu_addr = 4; lsu_data = 32'h44;
        @(negedge clk);
        n_cmp++; if (lsu_rdy !== 1'b1) begin n_err++; $display("FAIL x0_rdy: got %b want 1", lsu_rdy); end
        tick();
        lsu_vd = 0;
        @(negedge clk);
        n_cmp++; if (w_req !== 1'b0 || lsu_rdy !== 1'b1) begin n_err++; $display("FAIL x0_no_write: got req %b rdy %b want 0 1", w_req, lsu_rdy); end
        tick();
        @(negedge clk);
        n_cmp++; if ({w_req, w_addr, w_data} !== {1'b1, 5'd4, 32'h44}) begin n_err++; $display("FAIL x0_popped: got %b/%0d/%0h want 1/4/44", w_req, w_addr, w_data); end
        tick();
    endtask

    task automatic test_set_wins();
        idle();
        ld_issue = 1; ld_rd = 9;
        tick();
        ld_issue = 0; lsu_vd = 1; lsu_addr = 9; lsu_data = 32'h99;
        tick();
        lsu_vd = 0;
        tick();
        ld_issue = 1; ld_rd = 9;
        @(negedge clk);
        n_cmp++; if ({w_req, w_addr} !== {1'b1, 5'd9}) begin n_err++; $display("FAIL setwins_commit: got %b/%0d want 1/9", w_req, w_addr); end
        tick();
        ld_issue = 0; rs1 = 9; lsu_vd = 1; lsu_addr = 9; lsu_data = 32'h77;
        @(negedge clk);
        n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL setwins_pending: got %b want 1", hazard); end
        tick();
        lsu_vd = 0;
        tick();
        @(negedge clk);
        n_cmp++; if ({w_req, w_addr, w_data} !== {1'b1, 5'd9, 32'h77}) begin n_err++; $display("FAIL setwins_second: got %b/%0d/%0h want 1/9/77", w_req, w_addr, w_data); end
        tick();
        @(negedge clk);
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL setwins_clear: got %b want 0", hazard); end
        tick();
    endtask

    task automatic test_fwd();
        idle();
        alu_vd = 1; alu_addr = 3; alu_data = 32'h55;
        tick();
        idle(); rs1 = 3; rs2 = 4;
        @(negedge clk);
`ifdef YCR_WB_FWD_EN
        n_cmp++; if ({fwd1, fwd2} !== 2'b10 || fwd_data !== 32'h55) begin n_err++; $display("FAIL fwd_on: got %b%b/%0h want 10/55", fwd1, fwd2, fwd_data); end
`else
        n_cmp++; if ({fwd1, fwd2} !== 2'b00 || fwd_data !== 32'h0) begin n_err++; $display("FAIL fwd_off: got %b%b/%0h want 00/0", fwd1, fwd2, fwd_data); end
`endif
        tick();
    endtask

    task automatic test_random();
        logic [4:0] outq[$];
        logic [4:0] r;
        logic       e_haz, e_f1, e_f2;
        idle();
        rst_n = 0; #2; model_reset();
        @(negedge clk) rst_n = 1;
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) begin
                // asynchronous reset in the middle of traffic
                idle(); rst_n = 0; #1;
                n_cmp++; if (w_req !== 1'b0 || lsu_rdy !== 1'b1 || hazard !== 1'b0) begin n_err++; $display("FAIL mid_reset: got req %b rdy %b haz %b want 0 1 0", w_req, lsu_rdy, hazard); end
                model_reset(); outq.delete();
                @(negedge clk) rst_n = 1;
                tick();
            end
            alu_vd = ($urandom_range(0, 2) != 0);
            r = 5'($urandom_range(0, 31));
            for (int k = 0; k < 8 && r != 0 && pend_m[r]; k++) r = 5'($urandom_range(0, 31));
            if (r != 0 && pend_m[r]) r = 0;
            alu_addr = r; alu_data = $urandom;
            ld_issue = 0; ld_rd = 0;
            if (outq.size() < 4 && $urandom_range(0, 2) == 0) begin
                r = 5'($urandom_range(0, 31));
                if (!pend_m[r]) begin ld_issue = 1; ld_rd = r; end
            end
            lsu_vd = (outq.size() > 0) && ($urandom_range(0, 1) == 1);
            lsu_addr = (outq.size() > 0) ? outq[0] : 5'd0;
            lsu_data = $urandom;
            rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
            @(negedge clk);
            e_haz = (rs1 != 0 && pend_m[rs1]) || (rs2 != 0 && pend_m[rs2]) || (rd != 0 && pend_m[rd]);
            n_cmp++; if (lsu_rdy !== (mq_a.size() < DEPTH)) begin n_err++; $display("FAIL rnd_rdy c%0d: got %b want %b", cyc, lsu_rdy, mq_a.size() < DEPTH); end
            n_cmp++; if (hazard !== e_haz) begin n_err++; $display("FAIL rnd_hazard c%0d: got %b want %b", cyc, hazard, e_haz); end
            n_cmp++; if (w_req !== m_req) begin n_err++; $display("FAIL rnd_wreq c%0d: got %b want %b", cyc, w_req, m_req); end
            if (m_req) begin
                n_cmp++; if (w_addr !== m_addr || w_data !== m_data) begin n_err++; $display("FAIL rnd_wdata c%0d: got %0d/%0h want %0d/%0h", cyc, w_addr, w_data, m_addr, m_data); end
            end
`ifdef YCR_WB_FWD_EN
            e_f1 = m_req && rs1 != 0 && rs1 == m_addr;
            e_f2 = m_req && rs2 != 0 && rs2 == m_addr;
`else
            e_f1 = 0; e_f2 = 0;
`endif
            n_cmp++; if (fwd1 !== e_f1 || fwd2 !== e_f2) begin n_err++; $display("FAIL rnd_fwd c%0d: got %b%b want %b%b", cyc, fwd1, fwd2, e_f1, e_f2); end
            if (lsu_vd && mq_a.size() < DEPTH) void'(outq.pop_front());
            if (ld_issue) outq.push_back(ld_rd);
            model_step();
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        test_reset();
        test_alu_basic();
        test_load_hazard();
        test_burst();
        test_x0_load();
        test_set_wins();
        test_fwd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
